// File: rtl/accel_run_pkg.sv
// rtl/accel_run_pkg.sv - shared register map, bit indices and FSM states for accel_run_ctrl
package accel_run_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CYCLES = 2'd2;
   localparam logic [1:0] ADDR_TMO    = 2'd3;

   // CTRL bits
   localparam int GO     = 0;
   localparam int IRQ_EN = 1;
   localparam int ABORT  = 2;

   // STATUS bits
   localparam int BUSY = 0;
   localparam int DONE = 1;
   localparam int TMO  = 2;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT
   } state_t;

endpackage

// File: rtl/run_cycle_counter.sv
// rtl/run_cycle_counter.sv - 32-bit run-length counter with load-to-1 and saturation
module run_cycle_counter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic        en,
   output logic [31:0] count
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= 32'd1;
      end else if (en && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/accel_run_ctrl.sv
// rtl/accel_run_ctrl.sv - Avalon-MM run sequencer: start pulse, done wait, run timing, timeout and irq
module accel_run_ctrl
   import accel_run_pkg::*;
#(
   parameter int          START_HOLD      = 1,
   parameter logic [31:0] TIMEOUT_DEFAULT = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        start_out,
   input  logic        done_in,
   output logic        irq
);

   localparam int HW = (START_HOLD < 2) ? 1 : $clog2(START_HOLD + 1);

   state_t          state;
   logic [HW-1:0]   hold;
   logic [31:0]     cnt;
   logic [31:0]     cycles;
   logic [31:0]     timeout_lim;
   logic            irq_en;
   logic            done_flag;
   logic            tmo_flag;

   logic wr;
   logic go_wr;
   logic abort_wr;
   logic status_wr;
   logic cnt_load;
   logic timeout_hit;

   assign wr        = chipselect & ~write_n;
   assign go_wr     = wr && (address == ADDR_CTRL) && writedata[GO];
   assign abort_wr  = wr && (address == ADDR_CTRL) && writedata[ABORT];
   assign status_wr = wr && (address == ADDR_STATUS);
   assign cnt_load  = (state == IDLE) && go_wr && !abort_wr;

   // >= rather than == so a limit already passed (small limit, or lowered mid-run) fires at once
   assign timeout_hit = (timeout_lim != 32'd0) && (cnt >= timeout_lim);

   run_cycle_counter u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (cnt_load),
      .en      (state != IDLE),
      .count   (cnt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         hold        <= '0;
         start_out   <= 1'b0;
         cycles      <= '0;
         timeout_lim <= TIMEOUT_DEFAULT;
         irq_en      <= 1'b0;
         done_flag   <= 1'b0;
         tmo_flag    <= 1'b0;
      end else begin
         if (wr && (address == ADDR_CTRL)) begin
            irq_en <= writedata[IRQ_EN];
         end
         if (wr && (address == ADDR_TMO)) begin
            timeout_lim <= writedata;
         end
         // clears first so a set from the FSM below overrides them
         if (status_wr && writedata[DONE]) begin
            done_flag <= 1'b0;
         end
         if (status_wr && writedata[TMO]) begin
            tmo_flag <= 1'b0;
         end

         if (abort_wr) begin
            state     <= IDLE;
            start_out <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (go_wr) begin
                     state     <= LAUNCH;
                     start_out <= 1'b1;
                     hold      <= HW'(START_HOLD);
                  end
               end
               LAUNCH: begin
                  if (hold == HW'(1)) begin
                     state     <= WAIT;
                     start_out <= 1'b0;
                  end else begin
                     hold <= hold - 1'b1;
                  end
               end
               WAIT: begin
                  if (done_in) begin
                     state     <= IDLE;
                     done_flag <= 1'b1;
                     cycles    <= cnt;
                  end else if (timeout_hit) begin
                     state    <= IDLE;
                     tmo_flag <= 1'b1;
                     cycles   <= cnt;
                  end
               end
               default: begin
                  state     <= IDLE;
                  start_out <= 1'b0;
               end
            endcase
         end
      end
   end

   assign irq = irq_en & (done_flag | tmo_flag);

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL:   readdata[IRQ_EN] = irq_en;
         ADDR_STATUS: begin
            readdata[BUSY] = (state != IDLE);
            readdata[DONE] = done_flag;
            readdata[TMO]  = tmo_flag;
         end
         ADDR_CYCLES: readdata = cycles;
         ADDR_TMO:    readdata = timeout_lim;
         default:     readdata = '0;
      endcase
   end

endmodule
